// File: rtl/sid_write_sequencer_if.sv
// sid_write_sequencer_if
//   Bundles the request handshake from the host-side controller and the
//   replayed SID register-bus outputs of sid_write_sequencer.
//
//   Requester side (master drives, slave receives):
//     req_valid       write request valid
//     req_voice[1:0]  voice select (0-2 voices, 3 = filter/volume block)
//     req_addr[2:0]   register address within the selected voice/block
//     req_data[7:0]   register data
//   Sequencer side (slave drives, master observes):
//     req_ready       FIFO can accept a request this cycle
//     bus_ctrl[7:0]   to tt_um_sid ui_in: {strobe, 2'b00, voice, addr}
//     bus_data[7:0]   to tt_um_sid uio_in: register data
//     busy            FIFO non-empty or a write in flight
//     level           FIFO occupancy
//     done            one-cycle pulse in the final hold cycle of a write
interface sid_write_sequencer_if #(
    parameter int DEPTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               req_voice;
    logic [2:0]               req_addr;
    logic [7:0]               req_data;
    logic [7:0]               bus_ctrl;
    logic [7:0]               bus_data;
    logic                     busy;
    logic [$clog2(DEPTH):0]   level;
    logic                     done;

    // Requester: issues writes and watches progress.
    modport master (
        output req_valid, req_voice, req_addr, req_data,
        input  req_ready, bus_ctrl, bus_data, busy, level, done
    );

    // Sequencer: accepts writes and drives the SID register bus.
    modport slave (
        input  req_valid, req_voice, req_addr, req_data,
        output req_ready, bus_ctrl, bus_data, busy, level, done
    );
endinterface

// File: rtl/sid_write_sequencer.sv
// sid_write_sequencer
//   Queues SID register writes in a small FIFO and replays them, one at a
//   time in strict order, onto the tt_um_sid register bus with programmable
//   setup / strobe / hold timing so requesters need not care about bus timing.
//
//   Ports:
//     clk    system clock
//     rst_n  synchronous active-low reset
//     bus    sid_write_sequencer_if.slave (request handshake + SID bus outputs)
//
//   Parameters:
//     DEPTH          FIFO entries (power of two, >= 2)
//     SETUP_CYCLES   cycles addr/data stable with strobe low before the pulse
//     STROBE_CYCLES  cycles strobe held high
//     HOLD_CYCLES    cycles addr/data held with strobe low after the pulse
module sid_write_sequencer #(
    parameter int DEPTH         = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sid_write_sequencer_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t               state;
    logic [3:0]           phase;
    logic [12:0]          mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LEVEL_W-1:0]   level_q;
    logic [LEVEL_W-1:0]   level_next;
    logic                 ready;
    logic                 push;
    logic                 pop;
    logic                 phase_end;
    logic                 write_free;
    logic                 strobe_q;
    logic [4:0]           sel_q;
    logic [7:0]           data_q;
    logic                 done_q;
    logic                 busy_q;
    logic [12:0]          head;

    // A full FIFO refuses pushes even when a pop happens on the same edge,
    // which keeps ready a pure function of registered state.
    assign ready      = rst_n & (level_q != LEVEL_W'(DEPTH));
    assign push       = bus.req_valid & ready;
    assign phase_end  = (phase == 4'd0);
    // The FSM can take a new entry when idle or at the last hold cycle.
    assign write_free = (state == IDLE) | ((state == HOLD) & phase_end);
    assign pop        = write_free & (level_q != '0);
    assign level_next = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
    assign head       = mem[rd_ptr];

    assign bus.req_ready = ready;
    assign bus.bus_ctrl  = {strobe_q, 2'b00, sel_q};
    assign bus.bus_data  = data_q;
    assign bus.busy      = busy_q;
    assign bus.level     = level_q;
    assign bus.done      = done_q;

    // Storage is not reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.req_voice, bus.req_addr, bus.req_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_next;
        end
    end

    // Write FSM. The phase counter is loaded with (cycles - 1) on entry to
    // each phase and the phase ends when it reaches zero. done is raised on
    // the transition into the final hold cycle so it is registered. busy is
    // computed from next-state values so it drops on the very edge the FSM
    // settles in IDLE with nothing queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= 4'd0;
            strobe_q <= 1'b0;
            sel_q    <= 5'd0;
            data_q   <= 8'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= !(write_free && (level_q == '0) && (level_next == '0));
            case (state)
                IDLE: begin
                    if (pop) begin
                        sel_q  <= head[12:8];
                        data_q <= head[7:0];
                        phase  <= 4'(SETUP_CYCLES - 1);
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        strobe_q <= 1'b1;
                        phase    <= 4'(STROBE_CYCLES - 1);
                        state    <= STROBE;
                    end else begin
                        phase <= phase - 4'd1;
                    end
                end
                STROBE: begin
                    if (phase_end) begin
                        strobe_q <= 1'b0;
                        phase    <= 4'(HOLD_CYCLES - 1);
                        done_q   <= (HOLD_CYCLES == 1);
                        state    <= HOLD;
                    end else begin
                        phase <= phase - 4'd1;
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        if (pop) begin
                            sel_q  <= head[12:8];
                            data_q <= head[7:0];
                            phase  <= 4'(SETUP_CYCLES - 1);
                            state  <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        phase  <= phase - 4'd1;
                        done_q <= (phase == 4'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sid_write_sequencer.sv
// tb_sid_write_sequencer
//   Self-checking bench for sid_write_sequencer with default parameters.
//   Expected bus words are queued when a request is accepted and checked by
//   a monitor each time a strobe pulse begins.
module tb_sid_write_sequencer;
    logic clk;
    logic rst_n;

    int assertions = 0;
    int failures   = 0;
    int cycle      = 0;
    int strobe_cnt = 0;
    int done_cnt   = 0;
    logic prev_strobe = 1'b0;
    logic [14:0] held;

    logic [14:0] exp_q[$];
    int          rise_q[$];

    sid_write_sequencer_if #(.DEPTH(4)) sif ();

    sid_write_sequencer #(
        .DEPTH(4), .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: on each strobe rising edge pop the next expected write and
    // compare it; while strobe stays high the bus must not move. Counts
    // strobe and done pulses for the scenario tasks.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (sif.bus_ctrl[7] === 1'b1 && prev_strobe !== 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            rise_q.push_back(cycle);
            held = {sif.bus_ctrl[6:0], sif.bus_data};
            assertions = assertions + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("[TB] FAIL unexpected_strobe: got bus %h with no write pending", held);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if (held !== e) begin
                    failures = failures + 1;
                    $display("[TB] FAIL scoreboard_write: got %h expected %h", held, e);
                end
            end
        end else if (sif.bus_ctrl[7] === 1'b1) begin
            assertions = assertions + 1;
            if ({sif.bus_ctrl[6:0], sif.bus_data} !== held) begin
                failures = failures + 1;
                $display("[TB] FAIL bus_stable: got %h expected %h",
                         {sif.bus_ctrl[6:0], sif.bus_data}, held);
            end
        end
        if (sif.done === 1'b1) done_cnt = done_cnt + 1;
        prev_strobe = sif.bus_ctrl[7];
    end

    function automatic logic [7:0] ctrl_of(input logic s, input logic [1:0] v,
                                           input logic [2:0] a);
        return {s, 2'b00, v, a};
    endfunction

    // Offers one request and returns just after the edge that accepted it.
    // req_valid is left high so callers can stream requests back to back.
    task automatic push_req(input logic [1:0] v, input logic [2:0] a,
                            input logic [7:0] d, output logic saw_stall);
        logic rdy;
        bit   ok;
        saw_stall = 1'b0;
        ok = 0;
        sif.req_valid = 1'b1;
        sif.req_voice = v;
        sif.req_addr  = a;
        sif.req_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = sif.req_ready;
            @(posedge clk);
            if (rdy === 1'b1) begin
                ok = 1;
                break;
            end
            saw_stall = 1'b1;
        end
        #1;
        if (ok) begin
            exp_q.push_back({ctrl_of(1'b0, v, a)[6:0], d});
        end else begin
            assertions = assertions + 1;
            failures = failures + 1;
            $display("[TB] FAIL push_timeout: req_ready never 1 for voice %0d addr %0d", v, a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sif.req_valid = 1'b1;
        sif.req_voice = 2'd1;
        sif.req_addr  = 3'd2;
        sif.req_data  = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            assertions = assertions + 1;
            if (sif.req_ready !== 1'b0) begin
                failures = failures + 1;
                $display("[TB] FAIL reset_ready[%0d]: got %b expected 0", i, sif.req_ready);
            end
        end
        assertions = assertions + 5;
        if (sif.bus_ctrl !== 8'h00) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_bus_ctrl: got %h expected 00", sif.bus_ctrl);
        end
        if (sif.bus_data !== 8'h00) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_bus_data: got %h expected 00", sif.bus_data);
        end
        if (sif.level !== 3'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_level: got %0d expected 0", sif.level);
        end
        if (sif.busy !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_busy: got %b expected 0", sif.busy);
        end
        if (sif.done !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_done: got %b expected 0", sif.done);
        end
        @(posedge clk);
        #1;
        sif.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        assertions = assertions + 2;
        if (sif.level !== 3'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_no_push: got level %0d expected 0", sif.level);
        end
        if (sif.req_ready !== 1'b1) begin
            failures = failures + 1;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", sif.req_ready);
        end
    endtask

    // Single write with cycle-exact bus waveform check.
    task automatic test_single_write(input string name, input logic [1:0] v,
                                     input logic [2:0] a, input logic [7:0] d);
        logic       stall;
        logic [7:0] exp_ctrl [5];
        logic       exp_done [5];
        int         s0, d0;
        s0 = strobe_cnt;
        d0 = done_cnt;
        exp_ctrl = '{ctrl_of(1'b0, v, a), ctrl_of(1'b1, v, a), ctrl_of(1'b1, v, a),
                     ctrl_of(1'b0, v, a), ctrl_of(1'b0, v, a)};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        push_req(v, a, d, stall);
        sif.req_valid = 1'b0;
        @(negedge clk);
        assertions = assertions + 1;
        if (sif.level !== 3'd1) begin
            failures = failures + 1;
            $display("[TB] FAIL %s level_after_push: got %0d expected 1", name, sif.level);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            assertions = assertions + 3;
            if (sif.bus_ctrl !== exp_ctrl[k]) begin
                failures = failures + 1;
                $display("[TB] FAIL %s ctrl[%0d]: got %h expected %h", name, k, sif.bus_ctrl, exp_ctrl[k]);
            end
            if (sif.bus_data !== d) begin
                failures = failures + 1;
                $display("[TB] FAIL %s data[%0d]: got %h expected %h", name, k, sif.bus_data, d);
            end
            if (sif.done !== exp_done[k]) begin
                failures = failures + 1;
                $display("[TB] FAIL %s done[%0d]: got %b expected %b", name, k, sif.done, exp_done[k]);
            end
        end
        assertions = assertions + 4;
        if (sif.busy !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL %s busy_end: got %b expected 0", name, sif.busy);
        end
        if (strobe_cnt - s0 != 1) begin
            failures = failures + 1;
            $display("[TB] FAIL %s strobe_count: got %0d expected 1", name, strobe_cnt - s0);
        end
        if (done_cnt - d0 != 1) begin
            failures = failures + 1;
            $display("[TB] FAIL %s done_count: got %0d expected 1", name, done_cnt - d0);
        end
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL %s pending: got %0d expected 0", name, exp_q.size());
        end
    endtask

    // Six writes with req_valid held high; FIFO must back-pressure.
    task automatic test_back_to_back();
        logic stall;
        logic any_stall;
        int   s0, d0, n;
        bit   idle;
        s0 = strobe_cnt;
        d0 = done_cnt;
        any_stall = 1'b0;
        rise_q.delete();
        for (int i = 0; i < 6; i++) begin
            push_req(2'(i % 4), 3'(i + 1), 8'(8'h31 + 8'(i * 17)), stall);
            any_stall = any_stall | stall;
        end
        sif.req_valid = 1'b0;
        idle = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sif.busy === 1'b0) begin
                idle = 1;
                break;
            end
        end
        assertions = assertions + 6;
        if (!idle) begin
            failures = failures + 1;
            $display("[TB] FAIL burst_idle_timeout: busy still %b", sif.busy);
        end
        if (any_stall !== 1'b1) begin
            failures = failures + 1;
            $display("[TB] FAIL burst_backpressure: got stall %b expected 1", any_stall);
        end
        if (strobe_cnt - s0 != 6) begin
            failures = failures + 1;
            $display("[TB] FAIL burst_strobes: got %0d expected 6", strobe_cnt - s0);
        end
        if (done_cnt - d0 != 6) begin
            failures = failures + 1;
            $display("[TB] FAIL burst_dones: got %0d expected 6", done_cnt - d0);
        end
        if (sif.level !== 3'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL burst_level: got %0d expected 0", sif.level);
        end
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL burst_pending: got %0d expected 0", exp_q.size());
        end
        n = rise_q.size();
        for (int i = 1; i < n; i++) begin
            assertions = assertions + 1;
            if (rise_q[i] - rise_q[i-1] != 4) begin
                failures = failures + 1;
                $display("[TB] FAIL burst_spacing[%0d]: got %0d expected 4", i, rise_q[i] - rise_q[i-1]);
            end
        end
    endtask

    // Reset during a strobe with three writes still queued.
    task automatic test_reset_mid_write();
        logic stall;
        int   s0;
        for (int i = 0; i < 4; i++) begin
            push_req(2'd2, 3'(i), 8'(8'hC0 + i), stall);
        end
        sif.req_valid = 1'b0;
        @(negedge clk);
        assertions = assertions + 2;
        if (sif.bus_ctrl[7] !== 1'b1) begin
            failures = failures + 1;
            $display("[TB] FAIL midreset_pre_strobe: got %b expected 1", sif.bus_ctrl[7]);
        end
        if (sif.level !== 3'd3) begin
            failures = failures + 1;
            $display("[TB] FAIL midreset_pre_level: got %0d expected 3", sif.level);
        end
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        assertions = assertions + 4;
        if (sif.bus_ctrl[7] !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL midreset_strobe: got %b expected 0", sif.bus_ctrl[7]);
        end
        if (sif.level !== 3'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL midreset_level: got %0d expected 0", sif.level);
        end
        if (sif.busy !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL midreset_busy: got %b expected 0", sif.busy);
        end
        if (sif.req_ready !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL midreset_ready: got %b expected 0", sif.req_ready);
        end
        s0 = strobe_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        assertions = assertions + 1;
        if (strobe_cnt != s0) begin
            failures = failures + 1;
            $display("[TB] FAIL midreset_no_pulses: got %0d extra expected 0", strobe_cnt - s0);
        end
        @(posedge clk);
        #1;
        test_single_write("post_reset", 2'd0, 3'd4, 8'h5A);
    endtask

    initial begin
        rst_n = 1'b0;
        sif.req_valid = 1'b0;
        sif.req_voice = 2'd0;
        sif.req_addr  = 3'd0;
        sif.req_data  = 8'd0;
        test_reset();
        @(posedge clk); #1;
        test_single_write("single_v0", 2'd0, 3'd0, 8'hD6);
        @(posedge clk); #1;
        test_single_write("filter_v3", 2'd3, 3'd3, 8'h0F);
        @(posedge clk); #1;
        test_back_to_back();
        @(posedge clk); #1;
        test_reset_mid_write();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
